swap_cmd_ctrl: RTL and testbench

Command-side controller that drives the port-remap interface (select/source/target) of the crossbar address-remap stage.
- Accepts remap requests over a valid/ready handshake and validates them.
- Quiesces traffic by blocking new transactions and draining all outstanding ones, then issues a single-cycle select pulse.
- Keeps a shadow copy of the remap table that mirrors the decoder's table exactly, and reports completion or error over a response handshake.

---
 rtl/swap_cmd_ctrl_if.sv | 38 +++
 rtl/swap_cmd_ctrl.sv | 134 +++++++++++++
 tb/tb_swap_cmd_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/swap_cmd_ctrl_if.sv
// rtl/swap_cmd_ctrl_if.sv - request/response, crossbar event and remap-port bundle for swap_cmd_ctrl
interface swap_cmd_ctrl_if #(
  parameter int N_INIT_PORT = 8,
  parameter int LOG_N_INIT  = 3
);
  logic                              req_valid_i;
  logic                              req_ready_o;
  logic [LOG_N_INIT-1:0]             req_source_i;
  logic [LOG_N_INIT-1:0]             req_target_i;
  logic                              aw_issue_i;
  logic                              ar_issue_i;
  logic                              b_done_i;
  logic                              r_done_i;
  logic                              block_o;
  logic                              select_o;
  logic [LOG_N_INIT-1:0]             source_o;
  logic [LOG_N_INIT-1:0]             target_o;
  logic [N_INIT_PORT*LOG_N_INIT-1:0] map_o;
  logic                              resp_valid_o;
  logic                              resp_ready_i;
  logic [1:0]                        resp_err_o;

  // Controller side
  modport slave (
    input  req_valid_i, req_source_i, req_target_i,
    input  aw_issue_i, ar_issue_i, b_done_i, r_done_i, resp_ready_i,
    output req_ready_o, block_o, select_o, source_o, target_o, map_o,
    output resp_valid_o, resp_err_o
  );

  // Requester / crossbar side
  modport master (
    output req_valid_i, req_source_i, req_target_i,
    output aw_issue_i, ar_issue_i, b_done_i, r_done_i, resp_ready_i,
    input  req_ready_o, block_o, select_o, source_o, target_o, map_o,
    input  resp_valid_o, resp_err_o
  );
endinterface

// File: rtl/swap_cmd_ctrl.sv
// rtl/swap_cmd_ctrl.sv - quiesce-and-remap command controller with shadow remap table
module swap_cmd_ctrl #(
  parameter int N_INIT_PORT = 8,
  parameter int LOG_N_INIT  = 3,
  parameter int CNT_W       = 5,
  parameter int TO_W        = 8
) (
  input logic             clk,
  input logic             rst_n,
  swap_cmd_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RESP} state_t;

  localparam logic [LOG_N_INIT:0] N_LIM   = (LOG_N_INIT+1)'(N_INIT_PORT);
  localparam logic [CNT_W+1:0]    CNT_MAX = (CNT_W+2)'((1 << CNT_W) - 1);

  state_t                            state_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [TO_W-1:0]                   to_q;
  logic [LOG_N_INIT-1:0]             src_q, tgt_q;
  logic [LOG_N_INIT-1:0]             source_q, target_q;
  logic [N_INIT_PORT*LOG_N_INIT-1:0] map_q;
  logic                              block_q, select_q, resp_valid_q;
  logic [1:0]                        err_q;

  logic [CNT_W+1:0] cnt_up, cnt_dn, cnt_diff;
  logic [CNT_W-1:0] cnt_nxt;
  logic [TO_W-1:0]  to_nxt;
  logic             bad_idx;
  logic             issue_now;

  // Net outstanding update: issues minus completions, clamped to [0, 2^CNT_W-1]
  always_comb begin
    cnt_up   = {2'b00, cnt_q} + {{(CNT_W+1){1'b0}}, bus.aw_issue_i}
                              + {{(CNT_W+1){1'b0}}, bus.ar_issue_i};
    cnt_dn   = {{(CNT_W+1){1'b0}}, bus.b_done_i} + {{(CNT_W+1){1'b0}}, bus.r_done_i};
    cnt_diff = cnt_up - cnt_dn;
    cnt_nxt  = cnt_q;
    if (cnt_dn > cnt_up)
      cnt_nxt = '0;
    else if (cnt_diff > CNT_MAX)
      cnt_nxt = '1;
    else
      cnt_nxt = cnt_diff[CNT_W-1:0];
  end

  assign bad_idx   = ({1'b0, bus.req_source_i} >= N_LIM) || ({1'b0, bus.req_target_i} >= N_LIM);
  assign issue_now = bus.aw_issue_i || bus.ar_issue_i;
  assign to_nxt    = to_q + 1'b1;

  // Outstanding-transaction counter runs in every state
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_nxt;
  end

  // Request sequencing: validate, drain, strobe the decoder, report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      to_q         <= '0;
      src_q        <= '0;
      tgt_q        <= '0;
      source_q     <= '0;
      target_q     <= '0;
      block_q      <= 1'b0;
      select_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 2'd0;
      for (int i = 0; i < N_INIT_PORT; i++)
        map_q[i*LOG_N_INIT +: LOG_N_INIT] <= LOG_N_INIT'(i);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            src_q <= bus.req_source_i;
            tgt_q <= bus.req_target_i;
            if (bad_idx) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 2'd1;
            end else begin
              state_q <= DRAIN;
              block_q <= 1'b1;
              to_q    <= '0;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == '0 && !issue_now) begin
            state_q  <= APPLY;
            select_q <= 1'b1;
            source_q <= src_q;
            target_q <= tgt_q;
          end else begin
            to_q <= to_nxt;
            if (to_nxt == {TO_W{1'b1}}) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 2'd2;
            end
          end
        end
        APPLY: begin
          // Shadow table changes on the same edge the decoder samples select
          select_q                               <= 1'b0;
          map_q[src_q*LOG_N_INIT +: LOG_N_INIT] <= tgt_q;
          state_q                                <= RESP;
          resp_valid_q                           <= 1'b1;
          err_q                                  <= 2'd0;
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            block_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.block_o      = block_q;
  assign bus.select_o     = select_q;
  assign bus.source_o     = source_q;
  assign bus.target_o     = target_q;
  assign bus.map_o        = map_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = err_q;
endmodule

// File: tb/tb_swap_cmd_ctrl.sv
// tb/tb_swap_cmd_ctrl.sv - directed self-checking bench for swap_cmd_ctrl
module tb_swap_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  swap_cmd_ctrl_if #(.N_INIT_PORT(8), .LOG_N_INIT(3)) bus ();
  swap_cmd_ctrl_if #(.N_INIT_PORT(6), .LOG_N_INIT(3)) bus6 ();

  swap_cmd_ctrl #(.N_INIT_PORT(8), .LOG_N_INIT(3), .CNT_W(5), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  swap_cmd_ctrl #(.N_INIT_PORT(6), .LOG_N_INIT(3), .CNT_W(5), .TO_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6.slave));

  logic [23:0] exp_map;
  logic [23:0] ident8;
  logic [17:0] ident6;
  int          sel_cyc, resp_cyc;
  logic        blk_ok, sel_seen, rv_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] src, input logic [2:0] tgt);
    bus.req_source_i = src;
    bus.req_target_i = tgt;
    bus.req_valid_i  = 1'b1;
    tick();
    bus.req_valid_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ident8[i*3 +: 3] = 3'(i);
    for (int i = 0; i < 6; i++) ident6[i*3 +: 3] = 3'(i);
    bus.req_valid_i = 0;  bus.req_source_i = 0; bus.req_target_i = 0;
    bus.aw_issue_i = 0;   bus.ar_issue_i = 0;   bus.b_done_i = 0; bus.r_done_i = 0;
    bus.resp_ready_i = 1;
    bus6.req_valid_i = 0; bus6.req_source_i = 0; bus6.req_target_i = 0;
    bus6.aw_issue_i = 0;  bus6.ar_issue_i = 0;  bus6.b_done_i = 0; bus6.r_done_i = 0;
    bus6.resp_ready_i = 1;

    // Reset state
    rst_n = 0;
    tick(); tick();
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_block", bus.block_o, 0);
    chk("rst_select", bus.select_o, 0);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_err", bus.resp_err_o, 0);
    chk("rst_src_tgt", {bus.source_o, bus.target_o}, 0);
    chk("rst_map", bus.map_o, ident8);
    chk("rst_cnt", dut.cnt_q, 0);
    rst_n = 1;
    tick();

    // Idle remap 2->5, no traffic
    exp_map = ident8;
    request(3'd2, 3'd5);
    chk("t1_c1_block", bus.block_o, 1);
    chk("t1_c1_select", bus.select_o, 0);
    chk("t1_c1_ready", bus.req_ready_o, 0);
    tick();
    chk("t1_c2_select", bus.select_o, 1);
    chk("t1_c2_src_tgt", {bus.source_o, bus.target_o}, {3'd2, 3'd5});
    chk("t1_c2_block", bus.block_o, 1);
    tick();
    exp_map[2*3 +: 3] = 3'd5;
    chk("t1_c3_select", bus.select_o, 0);
    chk("t1_c3_resp", {bus.resp_valid_o, bus.resp_err_o}, {1'b1, 2'd0});
    chk("t1_c3_block", bus.block_o, 1);
    chk("t1_c3_map", bus.map_o, exp_map);
    tick();
    chk("t1_c4_ready", bus.req_ready_o, 1);
    chk("t1_c4_block_resp", {bus.block_o, bus.resp_valid_o}, 0);

    // Drain wait: 3 AW outstanding, B at +4, +6, +9
    bus.aw_issue_i = 1;
    tick(); tick(); tick();
    bus.aw_issue_i = 0;
    chk("t2_cnt3", dut.cnt_q, 3);
    request(3'd0, 3'd7);
    sel_cyc = 0;
    blk_ok = 1;
    for (int k = 1; k <= 13; k++) begin
      if (bus.select_o && sel_cyc == 0) sel_cyc = k;
      if (k <= 12 && !bus.block_o) blk_ok = 0;
      if (k == 12) chk("t2_resp", {bus.resp_valid_o, bus.resp_err_o}, {1'b1, 2'd0});
      if (k == 13) chk("t2_block_drop", bus.block_o, 0);
      bus.b_done_i = (k == 4 || k == 6 || k == 9);
      tick();
    end
    bus.b_done_i = 0;
    chk("t2_select_cycle", sel_cyc, 11);
    chk("t2_block_held", blk_ok, 1);
    exp_map[0 +: 3] = 3'd7;
    chk("t2_map", bus.map_o, exp_map);

    // Counter arithmetic: underflow clamp, cancellation, saturation
    bus.b_done_i = 1; tick(); bus.b_done_i = 0;
    chk("t3_underflow", dut.cnt_q, 0);
    bus.aw_issue_i = 1; tick();
    chk("t3_one", dut.cnt_q, 1);
    bus.b_done_i = 1; tick();
    chk("t3_cancel", dut.cnt_q, 1);
    bus.aw_issue_i = 0; bus.r_done_i = 1; tick();
    chk("t3_double_done_clamp", dut.cnt_q, 0);
    bus.b_done_i = 0; bus.r_done_i = 0;
    bus.aw_issue_i = 1; bus.ar_issue_i = 1;
    repeat (20) tick();
    chk("t3_saturate", dut.cnt_q, 31);
    bus.ar_issue_i = 0; bus.b_done_i = 1; bus.r_done_i = 1; tick();
    chk("t3_net_minus1", dut.cnt_q, 30);
    bus.aw_issue_i = 0;
    repeat (16) tick();
    chk("t3_drain_clamp", dut.cnt_q, 0);
    bus.b_done_i = 0; bus.r_done_i = 0;

    // Drain timeout: one AW never completes
    bus.aw_issue_i = 1; tick(); bus.aw_issue_i = 0;
    bus.resp_ready_i = 0;
    request(3'd3, 3'd6);
    resp_cyc = 0;
    sel_seen = 0;
    for (int k = 1; k <= 400; k++) begin
      if (bus.select_o) sel_seen = 1;
      if (bus.resp_valid_o) begin
        resp_cyc = k;
        break;
      end
      tick();
    end
    chk("t4_resp_cycle", resp_cyc, 256);
    chk("t4_no_select", sel_seen, 0);
    chk("t4_err", bus.resp_err_o, 2);
    chk("t4_block", bus.block_o, 1);
    repeat (3) begin
      tick();
      chk("t4_hold", {bus.resp_valid_o, bus.resp_err_o}, {1'b1, 2'd2});
    end
    bus.resp_ready_i = 1;
    tick();
    chk("t4_after_hs", {bus.block_o, bus.resp_valid_o, bus.req_ready_o}, 3'b001);
    chk("t4_map", bus.map_o, exp_map);
    bus.b_done_i = 1; tick(); bus.b_done_i = 0;
    chk("t4_cnt_clear", dut.cnt_q, 0);

    // Bad index on the 6-port instance
    bus6.req_source_i = 3'd7; bus6.req_target_i = 3'd1; bus6.req_valid_i = 1;
    tick();
    bus6.req_valid_i = 0;
    chk("t5_src_resp", {bus6.resp_valid_o, bus6.resp_err_o}, {1'b1, 2'd1});
    chk("t5_src_block_sel", {bus6.block_o, bus6.select_o}, 0);
    tick();
    chk("t5_src_idle", {bus6.req_ready_o, bus6.resp_valid_o, bus6.block_o}, 3'b100);
    bus6.req_source_i = 3'd1; bus6.req_target_i = 3'd6; bus6.req_valid_i = 1;
    tick();
    bus6.req_valid_i = 0;
    chk("t5_tgt_resp", {bus6.resp_valid_o, bus6.resp_err_o}, {1'b1, 2'd1});
    chk("t5_tgt_block_sel", {bus6.block_o, bus6.select_o}, 0);
    tick();
    chk("t5_map6", bus6.map_o, ident6);
    bus6.req_source_i = 3'd5; bus6.req_target_i = 3'd0; bus6.req_valid_i = 1;
    tick();
    bus6.req_valid_i = 0;
    chk("t5_edge_valid_drain", {bus6.block_o, bus6.resp_valid_o}, 2'b10);
    tick(); tick(); tick();

    // Reset in DRAIN after an applied remap 1->4
    request(3'd1, 3'd4);
    tick(); tick(); tick();
    exp_map[1*3 +: 3] = 3'd4;
    chk("t6_map_before", bus.map_o, exp_map);
    bus.aw_issue_i = 1; tick(); bus.aw_issue_i = 0;
    request(3'd6, 3'd2);
    tick(); tick();
    chk("t6_in_drain", {bus.block_o, bus.req_ready_o}, 2'b10);
    rst_n = 0;
    tick();
    rst_n = 1;
    sel_seen = 0;
    rv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.select_o) sel_seen = 1;
      if (bus.resp_valid_o) rv_seen = 1;
      tick();
    end
    chk("t6_no_pulse_no_resp", {sel_seen, rv_seen}, 0);
    chk("t6_map_identity", bus.map_o, ident8);
    chk("t6_idle", {bus.req_ready_o, bus.block_o}, 2'b10);
    chk("t6_cnt", dut.cnt_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
